matmul_sequencer: RTL and testbench
===================================

# matmul_sequencer

Sequencer that performs the signed matrix multiply C = A × B for the AI accelerator. It sits between the Wishbone register file and the A/B/C matrix memories inside `AI_Accelerator_Top`. When the Wishbone "go" write arrives (register 5), it walks every (i, j, k) index triple. For each index it reads A and B through synchronous read ports, accumulates through a multiply-accumulate unit, and writes each finished element of C. It reports busy/done/err back to the register file.

## Interface
- `DATA_W`, 32: element width; A, B and C elements are signed two's complement.
- `DIM_W`, 4: index width; the maximum dimension is 2^DIM_W (16).
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle go pulse from the register-5 write.
- `op` in 32: operation register; only `OP_MATMUL` (1) is valid.
- `w_a`, `h_a`, `w_b`, `h_b` in DIM_W+1 each: matrix dimensions; legal range is 1..2^DIM_W.
- `a_row`, `a_col` out DIM_W each: A read address.
- `a_rdata` in DATA_W: A read data, valid 1 cycle after the address.
- `b_row`, `b_col` out DIM_W each: B read address.
- `b_rdata` in DATA_W: B read data, valid 1 cycle after the address.
- `c_we` out 1: C write strobe.
- `c_row`, `c_col` out DIM_W each: C write address.
- `c_wdata` out DATA_W: C write data.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse, coincident with `done`, on a rejected command.

## Operation
- States: IDLE, CHECK, FETCH, DRAIN, WRITE, FIN.
- IDLE
  - `start` = 1 → CHECK.
  - `start` in any other state is ignored.
- CHECK (1 cycle)
  - Rejects the command if any of the following holds: `op` ≠ 1, `w_a` ≠ `h_b`, any dimension is 0, or any dimension is > 2^DIM_W.
  - On rejection: go to FIN with `err` set; no `c_we` is ever asserted.
  - On acceptance: latch all dimensions, set i = j = k = 0, clear the accumulator, → FETCH.
- FETCH (`w_a` cycles)
  - Drive `a_row`=i, `a_col`=k, `b_row`=k, `b_col`=j.
  - From the second FETCH cycle on, accumulate acc += a_rdata × b_rdata (full 2·DATA_W signed product, accumulator 2·DATA_W+DIM_W bits).
  - k increments each cycle. After k = `w_a`−1 → DRAIN.
- DRAIN (1 cycle): accumulate the last product.
- WRITE (1 cycle)
  - `c_we` = 1, `c_row`=i, `c_col`=j, `c_wdata` = result (see Configuration).
  - Clear the accumulator and set k = 0.
  - Advance j. When j wraps past `w_b`−1, reset j to 0 and advance i.
  - After i = `h_a`−1 and j = `w_b`−1 → FIN; otherwise → FETCH.
- FIN (1 cycle): `done` = 1 (and `err` if the command was rejected), `busy` = 0, → IDLE.
- C is written in row-major order, exactly `h_a`·`w_b` writes per accepted command.
- `w_b` and `h_a` are independent of each other; non-square shapes are legal.

## Timing
- Reset values: `busy`, `done`, `err`, `c_we` = 0; all addresses and `c_wdata` = 0; state = IDLE.
- Reset mid-operation: returns to IDLE on the next edge. No further `c_we`. C contents already written are left as-is.
- `busy` rises the cycle after `start` and falls in the FIN cycle.
- Accepted command: `start` → `done` = 2 + `h_a`·`w_b`·(`w_a`+2) cycles.
- Rejected command: `start` → `done` = 2 cycles.
- Address outputs hold their last value outside FETCH. `c_we` is high only in WRITE.
- Dimensions are sampled only in CHECK; changing the inputs while busy has no effect.

## Configuration
- `MATMUL_SEQ_SATURATE_EN`
  - Defined: the result saturates to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Undefined: the result is the low DATA_W bits of the accumulator (two's-complement wrap).
  - All other behaviour and timing are identical in both cases.

## Structure
- Shared package / `constants.v`:
  - `OP_MATMUL` (= 1).
  - State encodings `MSEQ_IDLE`..`MSEQ_FIN`.
  - The existing `SEQ_BITS` index width, which equals DIM_W−1.
- One sub-module, `matmul_mac`: a signed multiply-accumulate with clear, enable and an optional saturating output stage. The sequencer owns the FSM and counters only.

## Test plan
- 2×2 multiply:
  - Stimulus: A = [[-3, -15], [-6, 7]], B = [[9, -15], [-2, -5]], `op`=1, all dims 2, `start`.
  - Required response: C = [[3, 120], [-68, 55]]; 4 `c_we` pulses in order (0,0), (0,1), (1,0), (1,1); `done` exactly 18 cycles after `start`.
- Dimension mismatch:
  - Stimulus: `w_a`=2, `h_b`=3 (also repeat with `op`=2).
  - Required response: `err` and `done` pulse 2 cycles after `start`; zero `c_we`.
- Overflow, 1×1:
  - Stimulus: A = 0x7FFFFFFF, B = 2.
  - Required response: with the macro defined, C = 0x7FFFFFFF; without it, C = 0xFFFFFFFE.
- Non-square shape:
  - Stimulus: `h_a`=1, `w_a`=`h_b`=3, `w_b`=2; A = [1, 2, 3], B = [[1, 0], [0, 1], [1, 1]].
  - Required response: C = [4, 5]; `done` 12 cycles after `start`.
- `start` pulsed again while `busy`:
  - Required response: ignored; the results and cycle count of the first command are unchanged.
- Reset mid-operation:
  - Stimulus: `wb_rst_i` asserted during FETCH of element (0,1) of the 2×2 case.
  - Required response: the next cycle shows IDLE with `busy`=0 and no `c_we`. A fresh `start` after reset yields the correct full result.

Source files
------------

// File: rtl/matmul_sequencer_pkg.sv
// Shared constants for the matrix-multiply sequencer: opcode, FSM encodings and index width.
package matmul_sequencer_pkg;

    localparam int          SEQ_BITS  = 3;
    localparam logic [31:0] OP_MATMUL = 32'd1;

    typedef enum logic [2:0] {
        MSEQ_IDLE  = 3'd0,
        MSEQ_CHECK = 3'd1,
        MSEQ_FETCH = 3'd2,
        MSEQ_DRAIN = 3'd3,
        MSEQ_WRITE = 3'd4,
        MSEQ_FIN   = 3'd5
    } mseq_state_e;

endpackage

// File: rtl/matmul_sequencer_mac.sv
// Signed multiply-accumulate with clear/enable and a result stage that wraps by default
// or saturates to DATA_W when MATMUL_SEQ_SATURATE_EN is defined.
module matmul_mac #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 2 * DATA_W + 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q, acc_d;

    always_comb begin
        prod  = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

`ifdef MATMUL_SEQ_SATURATE_EN
    logic [ACC_W-DATA_W:0] acc_hi;

    // In range exactly when every bit above the result's sign bit matches it.
    always_comb begin
        acc_hi = acc_q[ACC_W-1:DATA_W-1];
        if (acc_hi == '0 || acc_hi == '1) begin
            result = acc_q[DATA_W-1:0];
        end else if (acc_q[ACC_W-1]) begin
            result = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            result = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign result = acc_q[DATA_W-1:0];
`endif

endmodule

// File: rtl/matmul_sequencer.sv
// Walks (i, j, k) for C = A x B, driving synchronous A/B reads and C writes through matmul_mac.
// Result saturation is selected with the MATMUL_SEQ_SATURATE_EN macro.
module matmul_sequencer
    import matmul_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIM_W  = SEQ_BITS + 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic [31:0]       op,
    input  logic [DIM_W:0]    w_a,
    input  logic [DIM_W:0]    h_a,
    input  logic [DIM_W:0]    w_b,
    input  logic [DIM_W:0]    h_b,
    output logic [DIM_W-1:0]  a_row,
    output logic [DIM_W-1:0]  a_col,
    input  logic [DATA_W-1:0] a_rdata,
    output logic [DIM_W-1:0]  b_row,
    output logic [DIM_W-1:0]  b_col,
    input  logic [DATA_W-1:0] b_rdata,
    output logic              c_we,
    output logic [DIM_W-1:0]  c_row,
    output logic [DIM_W-1:0]  c_col,
    output logic [DATA_W-1:0] c_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int               DIM1_W  = DIM_W + 1;
    localparam logic [DIM_W:0]   MAX_DIM = {1'b1, {DIM_W{1'b0}}};
    localparam logic [DIM_W:0]   ONE     = DIM1_W'(1);

    mseq_state_e      state_q, state_d;
    logic [DIM_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DIM_W:0]   w_a_q, w_a_d, h_a_q, h_a_d, w_b_q, w_b_d;
    logic             err_q, err_d;
    logic             reject, k_last, j_last, i_last;
    logic             mac_clr, mac_en;
    logic [DATA_W-1:0] mac_result;

    assign reject = (op != OP_MATMUL) || (w_a != h_b)
                 || (w_a == '0) || (h_a == '0) || (w_b == '0) || (h_b == '0)
                 || (w_a > MAX_DIM) || (h_a > MAX_DIM) || (w_b > MAX_DIM) || (h_b > MAX_DIM);

    assign k_last = ({1'b0, k_q} == w_a_q - ONE);
    assign j_last = ({1'b0, j_q} == w_b_q - ONE);
    assign i_last = ({1'b0, i_q} == h_a_q - ONE);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        w_a_d   = w_a_q;
        h_a_d   = h_a_q;
        w_b_d   = w_b_q;
        err_d   = err_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        unique case (state_q)
            MSEQ_IDLE: begin
                if (start) state_d = MSEQ_CHECK;
            end
            MSEQ_CHECK: begin
                if (reject) begin
                    err_d   = 1'b1;
                    state_d = MSEQ_FIN;
                end else begin
                    err_d   = 1'b0;
                    w_a_d   = w_a;
                    h_a_d   = h_a;
                    w_b_d   = w_b;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    mac_clr = 1'b1;
                    state_d = MSEQ_FETCH;
                end
            end
            MSEQ_FETCH: begin
                // Read data lags the address by one cycle, so k = 0 has nothing to add yet.
                mac_en = (k_q != '0);
                if (k_last) state_d = MSEQ_DRAIN;
                else        k_d     = k_q + 1'b1;
            end
            MSEQ_DRAIN: begin
                mac_en  = 1'b1;
                state_d = MSEQ_WRITE;
            end
            MSEQ_WRITE: begin
                mac_clr = 1'b1;
                if (i_last && j_last) begin
                    state_d = MSEQ_FIN;
                end else begin
                    k_d     = '0;
                    state_d = MSEQ_FETCH;
                    if (j_last) begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            MSEQ_FIN: state_d = MSEQ_IDLE;
            default:  state_d = MSEQ_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= MSEQ_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            w_a_q   <= '0;
            h_a_q   <= '0;
            w_b_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            w_a_q   <= w_a_d;
            h_a_q   <= h_a_d;
            w_b_q   <= w_b_d;
            err_q   <= err_d;
        end
    end

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (2 * DATA_W + DIM_W)
    ) u_mac (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .clr      (mac_clr),
        .en       (mac_en),
        .a        (a_rdata),
        .b        (b_rdata),
        .result   (mac_result)
    );

    // Counters only move on edges into FETCH, so the addresses hold everywhere else.
    assign a_row   = i_q;
    assign a_col   = k_q;
    assign b_row   = k_q;
    assign b_col   = j_q;
    assign c_row   = i_q;
    assign c_col   = j_q;
    assign c_we    = (state_q == MSEQ_WRITE);
    assign c_wdata = c_we ? mac_result : '0;
    assign busy    = (state_q == MSEQ_CHECK) || (state_q == MSEQ_FETCH)
                  || (state_q == MSEQ_DRAIN) || (state_q == MSEQ_WRITE);
    assign done    = (state_q == MSEQ_FIN);
    assign err     = (state_q == MSEQ_FIN) && err_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed, table-driven bench for matmul_sequencer with behavioural A/B memories.
module tb_matmul_sequencer;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        start;
    logic [31:0] op;
    logic [4:0]  w_a, h_a, w_b, h_b;
    logic [3:0]  a_row, a_col, b_row, b_col, c_row, c_col;
    logic [31:0] a_rdata, b_rdata, c_wdata;
    logic        c_we, busy, done, err;

    matmul_sequencer dut (
        .wb_clk_i (clk),
        .wb_rst_i (wb_rst_i),
        .start    (start),
        .op       (op),
        .w_a      (w_a),
        .h_a      (h_a),
        .w_b      (w_b),
        .h_b      (h_b),
        .a_row    (a_row),
        .a_col    (a_col),
        .a_rdata  (a_rdata),
        .b_row    (b_row),
        .b_col    (b_col),
        .b_rdata  (b_rdata),
        .c_we     (c_we),
        .c_row    (c_row),
        .c_col    (c_col),
        .c_wdata  (c_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

`ifdef MATMUL_SEQ_SATURATE_EN
    localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] OVF_NEG = 32'h8000_0000;
`else
    localparam logic [31:0] OVF_POS = 32'hFFFF_FFFE;
    localparam logic [31:0] OVF_NEG = 32'h0000_0000;
`endif

    typedef struct {
        int          mset;
        logic [31:0] op;
        logic [4:0]  wa, ha, wb, hb;
        int          exp_cyc;
        logic        exp_err;
        int          exp_n;
        logic [3:0][31:0] exp_c;
    } vec_t;

    typedef struct {
        logic [3:0]  r;
        logic [3:0]  c;
        logic [31:0] d;
    } wr_t;

    logic [31:0] a_mem [16][16];
    logic [31:0] b_mem [16][16];
    wr_t         c_q[$];
    int          done_cnt;
    time         done_time;
    logic        done_err;
    int          checks   = 0;
    int          failures = 0;
    vec_t        vecs[9];

    always @(posedge clk) begin
        a_rdata <= a_mem[a_row][a_col];
        b_rdata <= b_mem[b_row][b_col];
    end

    always @(negedge clk) begin
        if (c_we) c_q.push_back('{r: c_row, c: c_col, d: c_wdata});
        if (done) begin
            done_cnt  = done_cnt + 1;
            done_time = $time;
            done_err  = err;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load_set(input int s);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                a_mem[r][c] = '0;
                b_mem[r][c] = '0;
            end
        end
        case (s)
            0: begin
                a_mem[0][0] = 32'(-3); a_mem[0][1] = 32'(-15);
                a_mem[1][0] = 32'(-6); a_mem[1][1] = 32'(7);
                b_mem[0][0] = 32'(9);  b_mem[0][1] = 32'(-15);
                b_mem[1][0] = 32'(-2); b_mem[1][1] = 32'(-5);
            end
            1: begin
                a_mem[0][0] = 32'd1; a_mem[0][1] = 32'd2; a_mem[0][2] = 32'd3;
                b_mem[0][0] = 32'd1; b_mem[0][1] = 32'd0;
                b_mem[1][0] = 32'd0; b_mem[1][1] = 32'd1;
                b_mem[2][0] = 32'd1; b_mem[2][1] = 32'd1;
            end
            2: begin
                a_mem[0][0] = 32'h7FFF_FFFF;
                b_mem[0][0] = 32'd2;
            end
            3: begin
                a_mem[0][0] = 32'h8000_0000;
                b_mem[0][0] = 32'd2;
            end
            4: begin
                for (int k = 0; k < 16; k++) begin
                    a_mem[0][k] = 32'd1;
                    b_mem[k][0] = 32'(k + 1);
                end
            end
            default: ;
        endcase
    endtask

    function automatic vec_t mk(input int s, input logic [31:0] o,
                                input logic [4:0] wa, input logic [4:0] ha,
                                input logic [4:0] wb, input logic [4:0] hb,
                                input int cyc, input logic e, input int n,
                                input logic [31:0] c0, input logic [31:0] c1,
                                input logic [31:0] c2, input logic [31:0] c3);
        vec_t v;
        v.mset = s; v.op = o; v.wa = wa; v.ha = ha; v.wb = wb; v.hb = hb;
        v.exp_cyc = cyc; v.exp_err = e; v.exp_n = n;
        v.exp_c[0] = c0; v.exp_c[1] = c1; v.exp_c[2] = c2; v.exp_c[3] = c3;
        return v;
    endfunction

    // Runs one command; restart_at > 0 re-pulses start (with junk inputs) that many cycles in.
    task automatic apply_vec(input vec_t v, input int restart_at, input string tag);
        time t0;
        int  n;
        int  rr, cc;
        load_set(v.mset);
        c_q.delete();
        done_cnt = 0;
        @(negedge clk);
        op = v.op; w_a = v.wa; h_a = v.ha; w_b = v.wb; h_b = v.hb;
        start = 1'b1;
        t0 = $time;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            #1;
            n = n + 1;
            start = (n == restart_at);
            if (n == restart_at) begin
                op = 32'd7; w_a = 5'd3; h_a = 5'd9; w_b = 5'd5; h_b = 5'd4;
            end
        end
        start = 1'b0;
        check({tag, " done_seen"}, 32'(done_cnt > 0), 32'd1);
        if (done_cnt > 0) begin
            check({tag, " cycles"}, 32'(int'((done_time - t0) / 10)), 32'(v.exp_cyc));
            check({tag, " err"}, 32'(done_err), 32'(v.exp_err));
        end
        repeat (20) @(negedge clk);
        #1;
        check({tag, " done_count"}, 32'(done_cnt), 32'd1);
        check({tag, " writes"}, 32'(c_q.size()), 32'(v.exp_n));
        for (int i = 0; i < v.exp_n && i < c_q.size(); i++) begin
            rr = i / int'(v.wb);
            cc = i % int'(v.wb);
            check($sformatf("%s c%0d row", tag, i), 32'(c_q[i].r), 32'(rr));
            check($sformatf("%s c%0d col", tag, i), 32'(c_q[i].c), 32'(cc));
            check($sformatf("%s c%0d data", tag, i), c_q[i].d, v.exp_c[i]);
        end
    endtask

    initial begin
        vecs[0] = mk(0, 32'd1, 5'd2, 5'd2, 5'd2, 5'd2, 18, 1'b0, 4,
                     32'd3, 32'd120, 32'(-68), 32'd55);
        vecs[1] = mk(0, 32'd1, 5'd2, 5'd2, 5'd2, 5'd3, 2, 1'b1, 0, 0, 0, 0, 0);
        vecs[2] = mk(0, 32'd2, 5'd2, 5'd2, 5'd2, 5'd2, 2, 1'b1, 0, 0, 0, 0, 0);
        vecs[3] = mk(0, 32'd1, 5'd2, 5'd2, 5'd0, 5'd2, 2, 1'b1, 0, 0, 0, 0, 0);
        vecs[4] = mk(0, 32'd1, 5'd17, 5'd1, 5'd1, 5'd17, 2, 1'b1, 0, 0, 0, 0, 0);
        vecs[5] = mk(2, 32'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5, 1'b0, 1, OVF_POS, 0, 0, 0);
        vecs[6] = mk(3, 32'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5, 1'b0, 1, OVF_NEG, 0, 0, 0);
        vecs[7] = mk(1, 32'd1, 5'd3, 5'd1, 5'd2, 5'd3, 12, 1'b0, 2, 32'd4, 32'd5, 0, 0);
        vecs[8] = mk(4, 32'd1, 5'd16, 5'd1, 5'd1, 5'd16, 20, 1'b0, 1, 32'd136, 0, 0, 0);

        load_set(0);
        done_cnt = 0;
        wb_rst_i = 1'b1;
        start    = 1'b0;
        op       = '0;
        w_a = '0; h_a = '0; w_b = '0; h_b = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset flags", 32'({busy, done, err, c_we}), 32'd0);
        check("reset addrs", 32'({a_row, a_col, b_row, b_col, c_row, c_col}), 32'd0);
        check("reset wdata", c_wdata, 32'd0);
        wb_rst_i = 1'b0;

        for (int v = 0; v < 9; v++) begin
            apply_vec(vecs[v], 0, $sformatf("v%0d", v));
        end

        // Last FETCH of the 2x2 case addresses (i=1, k=1, j=1); it must hold in IDLE.
        apply_vec(vecs[0], 0, "hold");
        check("hold addrs", 32'({a_row, a_col, b_row, b_col}), 32'h1111);

        apply_vec(vecs[0], 5, "restart");

        load_set(0);
        c_q.delete();
        done_cnt = 0;
        @(negedge clk);
        op = 32'd1; w_a = 5'd2; h_a = 5'd2; w_b = 5'd2; h_b = 5'd2;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("rst_mid fetch01 addrs", 32'({a_row, a_col, b_row, b_col}), 32'h0001);
        check("rst_mid busy before", 32'(busy), 32'd1);
        wb_rst_i = 1'b1;
        @(negedge clk);
        #1;
        wb_rst_i = 1'b0;
        check("rst_mid flags after", 32'({busy, done, err, c_we}), 32'd0);
        repeat (10) @(negedge clk);
        #1;
        check("rst_mid writes", 32'(c_q.size()), 32'd1);
        check("rst_mid no done", 32'(done_cnt), 32'd0);
        apply_vec(vecs[0], 0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
